updown_counter_mod: RTL and testbench

//  Parametrised up/down counter: programmable width, modulus, step and end-of-range mode (wrap/saturate).

---
 rtl/counters_pkg.sv | 26 ++
 rtl/updown_next_val.sv | 52 +++++
 rtl/updown_counter_mod.sv | 90 +++++++++
 tb/tb_updown_counter_mod.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/counters_pkg.sv
// Shared constants and elaboration-time parameter checking for the counters suite.
`ifndef COUNTERS_PKG_SV
`define COUNTERS_PKG_SV

package counters_pkg;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   // True when the up/down counter parameter set describes a buildable counter.
   function automatic bit updown_params_ok(input int width, input int modulus,
                                           input int step, input int saturate);
      return (width >= 1) && (width <= 30) &&
             (modulus >= 2) && (modulus <= (1 << width)) &&
             (step >= 1) && (step < modulus) &&
             ((saturate == int'(MODE_WRAP)) || (saturate == int'(MODE_SAT)));
   endfunction

endpackage

`define COUNTERS_PARAM_CHECK(ok, msg) \
   if (!(ok)) begin : g_param_error \
      $error(msg); \
   end

`endif

// File: rtl/updown_next_val.sv
// Next-value compute for one up or down step, with end-of-range wrap or clamp
// and the matching overflow/underflow indication.
module updown_next_val
   import counters_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int STEP     = 1,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir,
   output logic [WIDTH-1:0] next,
   output logic             ovf,
   output logic             unf
);

   localparam int             EW     = WIDTH + 1;
   localparam logic [EW-1:0]  MOD_E  = EW'(MODULUS);
   localparam logic [EW-1:0]  MAX_E  = EW'(MODULUS - 1);
   localparam logic [EW-1:0]  STEP_E = EW'(STEP);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);
   localparam bit             SAT    = (SATURATE == int'(MODE_SAT));

   logic [EW-1:0] count_e;
   logic [EW-1:0] sum;

   // One extra bit keeps count+STEP exact even when MODULUS == 2**WIDTH.
   always_comb begin
      count_e = {1'b0, count};
      sum     = count_e + STEP_E;
      next    = count;
      ovf     = 1'b0;
      unf     = 1'b0;
      if (dir) begin
         if (sum <= MAX_E) begin
            next = sum[WIDTH-1:0];
         end else begin
            ovf  = 1'b1;
            next = SAT ? MAX_W : WIDTH'(sum - MOD_E);
         end
      end else begin
         if (count_e >= STEP_E) begin
            next = WIDTH'(count_e - STEP_E);
         end else begin
            unf  = 1'b1;
            next = SAT ? '0 : WIDTH'(count_e + MOD_E - STEP_E);
         end
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, enable, wrap/saturate end-of-range,
// registered ovf/unf pulses and combinational min/max flags.
module updown_counter_mod
   import counters_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int STEP     = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_min
);

   `COUNTERS_PARAM_CHECK(updown_params_ok(WIDTH, MODULUS, STEP, SATURATE),
                         "updown_counter_mod: illegal WIDTH/MODULUS/STEP/SATURATE")

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             ovf_reg;
   logic             ovf_next;
   logic             unf_reg;
   logic             unf_next;
   logic             do_up;
   logic             do_down;
   logic [WIDTH-1:0] step_val;
   logic             step_ovf;
   logic             step_unf;

   assign do_up   = en & up & ~down;
   assign do_down = en & down & ~up;

   updown_next_val #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .STEP     (STEP),
      .SATURATE (SATURATE)
   ) u_next_val (
      .count (count_reg),
      .dir   (do_up),
      .next  (step_val),
      .ovf   (step_ovf),
      .unf   (step_unf)
   );

   // Load wins over counting and is not gated by en; out-of-range loads clamp.
   always_comb begin
      count_next = count_reg;
      ovf_next   = 1'b0;
      unf_next   = 1'b0;
      if (load) begin
         count_next = (load_val > MAX_W) ? MAX_W : load_val;
      end else if (do_up || do_down) begin
         count_next = step_val;
         ovf_next   = step_ovf;
         unf_next   = step_unf;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
      end
   end

   assign count  = count_reg;
   assign ovf    = ovf_reg;
   assign unf    = unf_reg;
   assign at_max = (count_reg == MAX_W);
   assign at_min = (count_reg == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: four parameterisations driven by
// directed vectors, with a negedge monitor checking queued expectations.
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] en_v = '0;
   logic [3:0] up_v = '0;
   logic [3:0] down_v = '0;
   logic [3:0] load_v = '0;
   logic [3:0] lv4 [3];
   logic [7:0] lv8 = '0;
   logic [3:0] cnt4 [3];
   logic [7:0] cnt8;
   logic [3:0] ovf_v, unf_v, amax_v, amin_v;

   int mods [4] = '{10, 10, 10, 256};

   typedef struct {
      int    id;
      int    cnt;
      bit    ovf;
      bit    unf;
      string tag;
   } exp_t;

   exp_t q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   // d0: MOD10 step1 wrap; d1: MOD10 step3 wrap; d2: MOD10 step1 sat; d3: 8-bit MOD256 step5 wrap
   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .STEP(1), .SATURATE(0)) d0 (
      .clk(clk), .reset(reset), .en(en_v[0]), .up(up_v[0]), .down(down_v[0]),
      .load(load_v[0]), .load_val(lv4[0]), .count(cnt4[0]), .ovf(ovf_v[0]),
      .unf(unf_v[0]), .at_max(amax_v[0]), .at_min(amin_v[0]));
   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .STEP(3), .SATURATE(0)) d1 (
      .clk(clk), .reset(reset), .en(en_v[1]), .up(up_v[1]), .down(down_v[1]),
      .load(load_v[1]), .load_val(lv4[1]), .count(cnt4[1]), .ovf(ovf_v[1]),
      .unf(unf_v[1]), .at_max(amax_v[1]), .at_min(amin_v[1]));
   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .STEP(1), .SATURATE(1)) d2 (
      .clk(clk), .reset(reset), .en(en_v[2]), .up(up_v[2]), .down(down_v[2]),
      .load(load_v[2]), .load_val(lv4[2]), .count(cnt4[2]), .ovf(ovf_v[2]),
      .unf(unf_v[2]), .at_max(amax_v[2]), .at_min(amin_v[2]));
   updown_counter_mod #(.WIDTH(8), .MODULUS(256), .STEP(5), .SATURATE(0)) d3 (
      .clk(clk), .reset(reset), .en(en_v[3]), .up(up_v[3]), .down(down_v[3]),
      .load(load_v[3]), .load_val(lv8), .count(cnt8), .ovf(ovf_v[3]),
      .unf(unf_v[3]), .at_max(amax_v[3]), .at_min(amin_v[3]));

   task automatic compare(input int id, input int ec, input bit eo, input bit eu,
                          input string tag);
      int act_cnt;
      bit emax, emin;
      act_cnt = (id < 3) ? int'(cnt4[id]) : int'(cnt8);
      emax = (ec == mods[id] - 1);
      emin = (ec == 0);
      total_cnt++;
      if (act_cnt == ec && ovf_v[id] == eo && unf_v[id] == eu &&
          amax_v[id] == emax && amin_v[id] == emin) begin
         pass_cnt++;
         $display("ok   %s d%0d count=%0d ovf=%0b unf=%0b max=%0b min=%0b",
                  tag, id, act_cnt, ovf_v[id], unf_v[id], amax_v[id], amin_v[id]);
      end else begin
         $display("FAIL %s d%0d got count=%0d ovf=%0b unf=%0b max=%0b min=%0b want count=%0d ovf=%0b unf=%0b max=%0b min=%0b",
                  tag, id, act_cnt, ovf_v[id], unf_v[id], amax_v[id], amin_v[id],
                  ec, eo, eu, emax, emin);
      end
   endtask

   // Monitor: the counter presents a new result after every edge, checked at the following negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            compare(e.id, e.cnt, e.ovf, e.unf, e.tag);
         end
      end
   end

   task automatic expect_now(input int id, input int c, input bit o, input bit u,
                             input string tag);
      exp_t e;
      e.id = id; e.cnt = c; e.ovf = o; e.unf = u; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic idle_all();
      en_v = '0; up_v = '0; down_v = '0; load_v = '0;
   endtask

   task automatic step(input int id, input bit e, input bit u, input bit d, input bit l,
                       input int lv, input int ec, input bit eo, input bit eu,
                       input string tag);
      @(negedge clk);
      idle_all();
      en_v[id] = e; up_v[id] = u; down_v[id] = d; load_v[id] = l;
      if (id < 3) lv4[id] = 4'(lv);
      else lv8 = 8'(lv);
      @(posedge clk);
      expect_now(id, ec, eo, eu, tag);
      #1 idle_all();
   endtask

   // Reference for the 8-bit, MODULUS=256, STEP=5, wrapping counter.
   task automatic ref_d3(input int c, input int op, input int lv,
                         output int nc, output bit no, output bit nu);
      nc = c; no = 1'b0; nu = 1'b0;
      case (op)
         1: begin
            if (c + 5 > 255) begin nc = c + 5 - 256; no = 1'b1; end
            else nc = c + 5;
         end
         2: begin
            if (c < 5) begin nc = c + 256 - 5; nu = 1'b1; end
            else nc = c - 5;
         end
         3: nc = lv;
         default: nc = c;
      endcase
   endtask

   initial begin
      int c3, nc3, lv;
      bit no3, nu3;
      lv4[0] = '0; lv4[1] = '0; lv4[2] = '0;
      #1;
      for (int i = 0; i < 4; i++) expect_now(i, 0, 0, 0, "reset_state");
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;

      // reset mid-count at 7
      for (int k = 1; k <= 7; k++) step(0, 1, 1, 0, 0, 0, k, 0, 0, "pre_rst_up");
      @(negedge clk);
      #1 reset = 1'b0;
      #1 compare(0, 0, 0, 0, "rst_async");
      for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0, 0, 0, 0, "rst_hold");
      @(negedge clk) reset = 1'b1;

      // wrap up 1..9,0
      for (int k = 1; k <= 10; k++) step(0, 1, 1, 0, 0, 0, k % 10, k == 10, 0, "wrap_up");
      // wrap down 9,8,7
      step(0, 1, 0, 1, 0, 0, 9, 0, 1, "wrap_dn_0");
      step(0, 1, 0, 1, 0, 0, 8, 0, 0, "wrap_dn");
      step(0, 1, 0, 1, 0, 0, 7, 0, 0, "wrap_dn");

      // control conflicts and load
      step(0, 0, 0, 0, 1, 5, 5, 0, 0, "load5");
      step(0, 1, 1, 1, 0, 0, 5, 0, 0, "up_and_dn");
      step(0, 0, 1, 0, 0, 0, 5, 0, 0, "en0_up");
      step(0, 0, 0, 1, 0, 0, 5, 0, 0, "en0_dn");
      step(0, 1, 0, 0, 0, 0, 5, 0, 0, "no_dir");
      step(0, 1, 1, 0, 1, 3, 3, 0, 0, "load_over_up");
      step(0, 0, 0, 0, 1, 10, 9, 0, 0, "load10_clamp");
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, "load0");
      step(0, 0, 0, 1, 1, 4, 4, 0, 0, "load_en0");
      step(0, 0, 0, 0, 1, 14, 9, 0, 0, "load14_clamp");

      // STEP=3 wrap
      step(1, 0, 0, 0, 1, 1, 1, 0, 0, "s3_load1");
      step(1, 1, 0, 1, 0, 0, 8, 0, 1, "s3_dn_wrap");
      step(1, 1, 1, 0, 0, 0, 1, 1, 0, "s3_up_wrap");
      step(1, 1, 1, 0, 0, 0, 4, 0, 0, "s3_up");

      // saturate
      step(2, 0, 0, 0, 1, 8, 8, 0, 0, "sat_load8");
      step(2, 1, 1, 0, 0, 0, 9, 0, 0, "sat_up");
      step(2, 1, 1, 0, 0, 0, 9, 1, 0, "sat_up_clamp");
      step(2, 1, 1, 0, 0, 0, 9, 1, 0, "sat_up_clamp");
      step(2, 0, 0, 0, 1, 0, 0, 0, 0, "sat_load0");
      step(2, 1, 0, 1, 0, 0, 0, 0, 1, "sat_dn_clamp");
      step(2, 1, 0, 1, 0, 0, 0, 0, 1, "sat_dn_clamp");
      step(2, 1, 1, 0, 0, 0, 1, 0, 0, "sat_up");

      // 8-bit, STEP=5
      step(3, 0, 0, 0, 1, 253, 253, 0, 0, "w8_load");
      step(3, 1, 1, 0, 0, 0, 2, 1, 0, "w8_up_wrap");
      step(3, 1, 0, 1, 0, 0, 253, 0, 1, "w8_dn_wrap");
      c3 = 253;
      for (int i = 0; i < 24; i++) begin
         int op;
         op = (i * 7 + 3) % 4;
         lv = (i * 37 + 11) % 256;
         ref_d3(c3, op, lv, nc3, no3, nu3);
         step(3, 1, op == 1, op == 2, op == 3, lv, nc3, no3, nu3, "w8_model");
         c3 = nc3;
      end

      // reset right after a wrap drops the pending ovf pulse (d0 sits at 9)
      @(negedge clk);
      idle_all();
      en_v[0] = 1'b1; up_v[0] = 1'b1;
      @(posedge clk);
      #1 idle_all();
      #1 reset = 1'b0;
      #1 compare(0, 0, 0, 0, "rst_drop_ovf");
      compare(3, 0, 0, 0, "rst_d3");
      @(negedge clk) reset = 1'b1;
      step(0, 1, 1, 0, 0, 0, 1, 0, 0, "post_rst_up");

      repeat (3) @(negedge clk);
      total_cnt++;
      if (q.size() != 0)
         $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
      else
         pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
